// File: rtl/mem_io_unit_if.sv
// Core-side data memory port: store strobe, byte address and store data in, load data out.
// The master modport is the core (or a bench standing in for it), the slave is the memory/IO unit.
interface mem_io_unit_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output ALUResult, output WriteData, input ReadData);
  modport slave  (input MemWrite, input ALUResult, input WriteData, output ReadData);
endinterface

// File: rtl/mem_io_unit.sv
// Data RAM, LED register, free-running timer and FIFO-buffered 8N1 UART transmitter
// behind the single-cycle core's memory port; loads are combinational from the address.
module mem_io_unit #(
  parameter int RAM_WORDS    = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_io_unit_if.slave       bus,
  output logic [7:0]         leds,
  output logic               tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);
  localparam logic [FW:0]   FIFO_FULL = (FW+1)'(FIFO_DEPTH);
  localparam logic [FW:0]   FIFO_ONE  = (FW+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    leds_q;
  logic [31:0]   timer_q, timer_d;
  logic          ovf_q, ovf_d;
  logic [FW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW:0]   cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  logic [29:0]   word_s;
  logic          sel_ram_s, sel_led_s, sel_tmr_s, sel_txd_s, sel_stat_s;
  logic          full_s, empty_s, busy_s, push_s, push_ok_s, pop_s;
  logic          unused_addr_s;

  assign word_s        = bus.ALUResult[31:2];
  assign unused_addr_s = ^bus.ALUResult[1:0];
  assign sel_ram_s     = (bus.ALUResult[31:AW+2] == '0);
  assign sel_led_s     = (word_s == 30'h2000_0000);
  assign sel_tmr_s     = (word_s == 30'h2000_0001);
  assign sel_txd_s     = (word_s == 30'h2000_0002);
  assign sel_stat_s    = (word_s == 30'h2000_0003);

  assign full_s    = (cnt_q == FIFO_FULL);
  assign empty_s   = (cnt_q == '0);
  assign busy_s    = (state_q != S_IDLE);
  // Acceptance looks only at pre-edge fullness, so a same-edge pop never frees room.
  assign push_s    = bus.MemWrite & sel_txd_s;
  assign push_ok_s = push_s & ~full_s;

  assign leds = leds_q;

  always_comb begin
    bus.ReadData = 32'h0000_0000;
    if (sel_ram_s)       bus.ReadData = ram_q[bus.ALUResult[AW+1:2]];
    else if (sel_led_s)  bus.ReadData = {24'h00_0000, leds_q};
    else if (sel_tmr_s)  bus.ReadData = timer_q;
    else if (sel_stat_s) bus.ReadData = {28'h000_0000, ovf_q, busy_s, full_s, empty_s};
    else                 bus.ReadData = 32'h0000_0000;
  end

  always_comb begin
    timer_d = (bus.MemWrite && sel_tmr_s) ? 32'h0000_0000 : timer_q + 32'h0000_0001;
    ovf_d   = ovf_q;
    if (push_s && full_s)               ovf_d = 1'b1;
    else if (bus.MemWrite && sel_stat_s) ovf_d = 1'b0;
    else                                ovf_d = ovf_q;
    case ({push_ok_s, pop_s})
      2'b10:   cnt_d = cnt_q + FIFO_ONE;
      2'b01:   cnt_d = cnt_q - FIFO_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          state_d = S_START;
          baud_d  = BIT_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BIT_LAST;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = BIT_LAST;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_STOP: begin
        // Chaining straight into the next start bit keeps back-to-back bytes gapless.
        if (baud_q != '0) begin
          baud_d = baud_q - BAUD_ONE;
        end else if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          state_d = S_START;
          baud_d  = BIT_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.MemWrite && sel_ram_s) ram_q[bus.ALUResult[AW+1:2]] <= bus.WriteData;
    if (push_ok_s) fifo_q[wr_ptr_q] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q   <= 8'h00;
      timer_q  <= 32'h0000_0000;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      if (bus.MemWrite && sel_led_s) leds_q <= bus.WriteData[7:0];
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)     rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end
endmodule
